// File: rtl/mcs40_pkg.sv
// MCS-40 subcycle encodings and widths shared by the timing
// generator and the CPU/ROM/RAM bus models.
package mcs40_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned WDOG_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } subcycle_t;

    function automatic subcycle_t next_sub(input subcycle_t s);
        return subcycle_t'(3'(s) + 3'd1);
    endfunction

endpackage

// File: rtl/mcs40_timing_gen_if.sv
// Two-phase clock bundle between the phase monitor and the
// subcycle sequencer.
interface mcs40_timing_gen_if;

    logic phi1;
    logic phi2;
    logic phi2_edge;
    logic err;

    modport master (
        input  phi1,
        input  phi2,
        output phi2_edge,
        output err
    );

    modport slave (
        output phi1,
        output phi2,
        input  phi2_edge,
        input  err
    );

endinterface

// File: rtl/mcs40_phase_mon.sv
// PHI2 rising-edge detect, inter-edge watchdog and
// phase-overlap check with a sticky fault flag.
module mcs40_phase_mon
    import mcs40_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    mcs40_timing_gen_if.master bus
);

    localparam logic [WDOG_W-1:0] LIM = WDOG_W'(WDOG_LIMIT);

    logic              phi2_q;
    logic [WDOG_W-1:0] wdog;
    logic [WDOG_W-1:0] wdog_nxt;
    logic              err_q;
    logic              overlap;

    assign bus.phi2_edge = bus.phi2 & ~phi2_q;
    assign overlap       = ~bus.phi1 & ~bus.phi2;
    assign bus.err       = err_q;

    // Saturates at the limit so a dead clock cannot wrap back to 0.
    always_comb begin
        wdog_nxt = wdog;
        if (bus.phi2_edge) begin
            wdog_nxt = '0;
        end else if (wdog != LIM) begin
            wdog_nxt = wdog + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phi2_q <= 1'b1;
            wdog   <= '0;
            err_q  <= 1'b0;
        end else begin
            phi2_q <= bus.phi2;
            wdog   <= wdog_nxt;
            if (overlap || (wdog_nxt == LIM)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mcs40_timing_gen.sv
// MCS-40 instruction-cycle sequencer: A1..X3 subcycles,
// SYNC, cycle counter and STOP handling.
module mcs40_timing_gen
    import mcs40_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               PHI1_i,
    input  logic               PHI2_i,
    input  logic               stop_i,
    output logic [STATE_W-1:0] state_o,
    output logic               SYNC_o,
    output logic               sub_stb_o,
    output logic [CNT_W-1:0]   cyc_cnt_o,
    output logic               stopped_o,
    output logic               phase_err_o
);

    mcs40_timing_gen_if pm ();

    assign pm.phi1 = PHI1_i;
    assign pm.phi2 = PHI2_i;

    mcs40_phase_mon #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_mon (
        .clk (clk_i),
        .rst (rst_i),
        .bus (pm)
    );

    subcycle_t        sub_q;
    subcycle_t        sub_d;
    logic             stp_q;
    logic             stp_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stb_q;
    logic             stb_d;
    logic             sync_q;
    logic             sync_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sub_q  <= A1;
            stp_q  <= 1'b0;
            cnt_q  <= '0;
            stb_q  <= 1'b0;
            sync_q <= 1'b1;
        end else begin
            sub_q  <= sub_d;
            stp_q  <= stp_d;
            cnt_q  <= cnt_d;
            stb_q  <= stb_d;
            sync_q <= sync_d;
        end
    end

    // Leaving STOP only clears the flag; the next edge advances.
    always_comb begin
        sub_d = sub_q;
        stp_d = stp_q;
        cnt_d = cnt_q;
        stb_d = 1'b0;
        if (pm.phi2_edge) begin
            if (stp_q) begin
                if (!stop_i) begin
                    stp_d = 1'b0;
                end
            end else if (sub_q == X3) begin
                sub_d = A1;
                if (stop_i) begin
                    stp_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    stb_d = 1'b1;
                end
            end else begin
                sub_d = next_sub(sub_q);
                stb_d = 1'b1;
            end
        end
        sync_d = !((sub_d == X3) && !stp_d);
    end

    assign state_o     = sub_q;
    assign SYNC_o      = sync_q;
    assign sub_stb_o   = stb_q;
    assign cyc_cnt_o   = cnt_q;
    assign stopped_o   = stp_q;
    assign phase_err_o = pm.err;

endmodule

// File: tb/tb_mcs40_timing_gen.sv
// Self-checking bench for mcs40_timing_gen: per-cycle scoreboard
// plus hand-derived vector table and corner sequences.
module tb_mcs40_timing_gen;

    localparam int WD = 15;

    typedef struct packed {
        logic [2:0] st;
        logic       sync_n;
        logic       stb;
        logic [7:0] cnt;
        logic       stp;
        logic       err;
    } out_t;

    typedef struct {
        int         k;
        logic [2:0] st;
        logic       sync_n;
        logic       stb;
        logic [7:0] cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       stop;
    logic [2:0] state;
    logic       sync_n;
    logic       stb;
    logic [7:0] cnt;
    logic       stopped;
    logic       err;

    mcs40_timing_gen_if bus ();

    mcs40_timing_gen #(
        .WDOG_LIMIT (WD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .PHI1_i      (bus.phi1),
        .PHI2_i      (bus.phi2),
        .stop_i      (stop),
        .state_o     (state),
        .SYNC_o      (sync_n),
        .sub_stb_o   (stb),
        .cyc_cnt_o   (cnt),
        .stopped_o   (stopped),
        .phase_err_o (err)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   passed = 0;
    int   gp = 0;
    out_t sbq[$];

    logic       m_q;
    logic [7:0] m_w;
    logic [2:0] m_st;
    logic       m_stp;
    logic [7:0] m_cnt;
    logic       m_err;
    logic       m_stb;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick(input logic r, input logic p1,
                        input logic p2, input logic st);
        out_t e;
        out_t a;
        logic ed;
        rst      = r;
        bus.phi1 = p1;
        bus.phi2 = p2;
        stop     = st;
        if (r) begin
            m_q = 1'b1; m_w = '0; m_st = '0; m_stp = 1'b0;
            m_cnt = '0; m_err = 1'b0; m_stb = 1'b0;
        end else begin
            ed    = p2 && !m_q;
            m_q   = p2;
            m_stb = 1'b0;
            if (!p1 && !p2) m_err = 1'b1;
            if (ed) m_w = '0;
            else if (m_w < 8'(WD)) m_w = m_w + 8'd1;
            if (m_w == 8'(WD)) m_err = 1'b1;
            if (ed) begin
                if (m_stp) begin
                    if (!st) m_stp = 1'b0;
                end else if (m_st == 3'd7) begin
                    m_st = 3'd0;
                    if (st) m_stp = 1'b1;
                    else begin
                        m_cnt = m_cnt + 8'd1;
                        m_stb = 1'b1;
                    end
                end else begin
                    m_st  = m_st + 3'd1;
                    m_stb = 1'b1;
                end
            end
        end
        e.st     = m_st;
        e.sync_n = !(m_st == 3'd7 && !m_stp);
        e.stb    = m_stb;
        e.cnt    = m_cnt;
        e.stp    = m_stp;
        e.err    = m_err;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        a.st = state; a.sync_n = sync_n; a.stb = stb;
        a.cnt = cnt; a.stp = stopped; a.err = err;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            chk("sb", 32'(a), 32'(sbq.pop_front()));
        end
    endtask

    // 7-clk two-phase clock; PHI2 rises at phase 6.
    task automatic clk7(input int n, input logic st);
        int p;
        for (int i = 0; i < n; i++) begin
            p = gp % 7;
            tick(1'b0, p >= 2, !(p >= 3 && p <= 5), st);
            gp++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_sync"}, 32'(sync_n), 1);
        chk({tag, "_stb"}, 32'(stb), 0);
        chk({tag, "_cnt"}, 32'(cnt), 0);
        chk({tag, "_stopped"}, 32'(stopped), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    vec_t vec[10];

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int vi;
        int sync_low;
        int found;
        logic stb_seen;
        logic sync_seen;

        vec[0] = '{5,   3'd0, 1'b1, 1'b0, 8'd0};
        vec[1] = '{6,   3'd1, 1'b1, 1'b1, 8'd0};
        vec[2] = '{7,   3'd1, 1'b1, 1'b0, 8'd0};
        vec[3] = '{13,  3'd2, 1'b1, 1'b1, 8'd0};
        vec[4] = '{47,  3'd6, 1'b1, 1'b0, 8'd0};
        vec[5] = '{48,  3'd7, 1'b0, 1'b1, 8'd0};
        vec[6] = '{54,  3'd7, 1'b0, 1'b0, 8'd0};
        vec[7] = '{55,  3'd0, 1'b1, 1'b1, 8'd1};
        vec[8] = '{62,  3'd1, 1'b1, 1'b1, 8'd1};
        vec[9] = '{111, 3'd0, 1'b1, 1'b1, 8'd2};

        bus.phi2_edge = 1'b0;
        bus.err       = 1'b0;

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);
        chk_reset("rst0");

        // Free-running clock against the vector table.
        gp = 0; vi = 0; sync_low = 0;
        for (int k = 0; k < 112; k++) begin
            clk7(1, 1'b0);
            if (k < 56 && !sync_n) sync_low++;
            if (vi < 10 && vec[vi].k == k) begin
                chk($sformatf("vec%0d", vi),
                    {20'd0, state, sync_n, stb, cnt},
                    {20'd0, vec[vi].st, vec[vi].sync_n,
                     vec[vi].stb, vec[vi].cnt});
                vi++;
            end
        end
        chk("sync_low_per_56", 32'(sync_low), 7);

        // Counter wrap.
        clk7(253 * 56, 1'b0);
        chk("cnt_255", 32'(cnt), 255);
        clk7(56, 1'b0);
        chk("cnt_wrap", 32'(cnt), 0);
        chk("wrap_state", 32'(state), 0);
        chk("wrap_err", 32'(err), 0);

        // STOP across X3->A1.
        found = 0;
        for (int i = 0; i < 70 && !found; i++) begin
            clk7(1, 1'b1);
            if (stopped) found = 1;
        end
        chk("stop_reached", 32'(found), 1);
        chk("stop_state", 32'(state), 0);
        chk("stop_sync", 32'(sync_n), 1);
        chk("stop_cnt", 32'(cnt), 0);
        stb_seen = 1'b0; sync_seen = 1'b0;
        for (int i = 0; i < 21; i++) begin
            clk7(1, 1'b1);
            stb_seen  = stb_seen | stb;
            sync_seen = sync_seen | !sync_n;
        end
        chk("stop_no_stb", 32'(stb_seen), 0);
        chk("stop_no_sync", 32'(sync_seen), 0);
        chk("stop_held", 32'(stopped), 1);
        clk7(7, 1'b0);
        chk("unstop_flag", 32'(stopped), 0);
        chk("unstop_state", 32'(state), 0);
        clk7(7, 1'b0);
        chk("resume_state", 32'(state), 1);
        chk("resume_cnt", 32'(cnt), 0);

        // Watchdog: PHI2 held high.
        for (int i = 1; i <= 20; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0);
            if (i == 14) chk("wdog_14", 32'(err), 0);
            if (i == 15) chk("wdog_15", 32'(err), 1);
        end
        gp = 0;
        clk7(28, 1'b0);
        chk("wdog_sticky", 32'(err), 1);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        chk("wdog_clr", 32'(err), 0);

        // Phase overlap.
        gp = 0;
        clk7(10, 1'b0);
        chk("pre_ovl", 32'(err), 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovl_err", 32'(err), 1);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        chk("ovl_clr", 32'(err), 0);

        // Reset at X1 with PHI2 high.
        gp = 0;
        clk7(35, 1'b0);
        chk("pre_rst_state", 32'(state), 5);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        chk_reset("rst5");
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("no_false_edge", 32'(state), 0);
        gp = 3;
        clk7(3, 1'b0);
        chk("pre_first_adv", 32'(state), 0);
        clk7(1, 1'b0);
        chk("first_adv", 32'(state), 1);
        chk("first_adv_stb", 32'(stb), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mcs40_timing_gen.md
MCS40_TIMING_GEN -- requirements
Module: mcs40_timing_gen

Interface
REQ-001 SHALL have parameter: WDOG_LIMIT, 15, clk_i cycles allowed between PHI2 rising edges before phase_err_o sets (range 8..255).
REQ-002 SHALL have port: clk_i  in  1  main design clock (not a pin); the only clock.
REQ-003 SHALL have port: rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: PHI1_i  in  1  phase-1 clock from the two-phase generator, active-low, same clk_i domain.
REQ-005 SHALL have port: PHI2_i  in  1  phase-2 clock, active-low, same clk_i domain.
REQ-006 SHALL have port: stop_i  in  1  stop request, level, sampled only at the X3->A1 boundary and while stopped.
REQ-007 SHALL have port: state_o  out  3  current subcycle: 0=A1 1=A2 2=A3 3=M1 4=M2 5=X1 6=X2 7=X3.
REQ-008 SHALL have port: SYNC_o  out  1  active-low SYNC; low exactly while state_o==X3 and not stopped.
REQ-009 SHALL have port: sub_stb_o  out  1  one-clk pulse marking each subcycle advance.
REQ-010 SHALL have port: cyc_cnt_o  out  8  completed instruction-cycle count.
REQ-011 SHALL have port: stopped_o  out  1  high while the sequencer is in STOP.
REQ-012 SHALL have port: phase_err_o  out  1  sticky clock-phase fault flag.

Function
REQ-013 SHALL register PHI2_i into phi2_q each clk; PHI2 edge = PHI2_i==1 and phi2_q==0.
REQ-014 SHALL advance state_o by one (7 wraps to 0) on the clk edge where a PHI2 edge is detected, unless in STOP; all outputs registered.
REQ-015 SHALL assert sub_stb_o for exactly the one clk following each state advance; never while stopped.
REQ-016 SHALL drive SYNC_o=0 in the same cycle state_o becomes 7 and return it to 1 in the cycle state_o becomes 0.
REQ-017 SHALL increment cyc_cnt_o on each X3->A1 advance, modulo 256 (255->0, no flag).
REQ-018 SHALL, on an X3->A1 PHI2 edge with stop_i=1, set state_o=0, stopped_o=1, not increment cyc_cnt_o, no sub_stb_o.
REQ-019 SHALL, while stopped, sample stop_i at each PHI2 edge; if 0, clear stopped_o, state_o stays 0; normal advance resumes at the following PHI2 edge.
REQ-020 SHALL keep SYNC_o=1 and cyc_cnt_o frozen while stopped.
REQ-021 SHALL count clk_i cycles since last PHI2 edge in a saturating counter; reaching WDOG_LIMIT sets phase_err_o.
REQ-022 SHALL set phase_err_o when PHI1_i==0 and PHI2_i==0 in the same clk (phase overlap).
REQ-023 SHALL keep phase_err_o set until rst_i; sequencing continues normally despite error.
REQ-024 SHALL treat a PHI2 edge and stop_i change in the same clk by using the stop_i value of that clk.

Reset
REQ-025 SHALL on rst_i=1 set: state_o=0, SYNC_o=1, sub_stb_o=0, cyc_cnt_o=0, stopped_o=0, phase_err_o=0, watchdog=0, phi2_q=1.
REQ-026 SHALL, because phi2_q resets to 1, not detect a PHI2 edge in the first clk after reset even if PHI2_i=1.
REQ-027 SHALL abandon any subcycle or STOP in progress when rst_i asserts mid-operation; rst_i overrides all.

Structure
REQ-028 SHALL place subcycle encodings (A1..X3) and the 3-bit state width in shared package mcs40_pkg for reuse by CPU/ROM/RAM models.
REQ-029 SHALL implement phase monitoring (edge detect, watchdog, overlap check) as sub-module mcs40_phase_mon producing phi2_edge and err outputs.

Verification
REQ-030 SHALL cover: free-running 7-clk two-phase clock after reset -> state_o 0..7 repeats every 56 clk, SYNC_o low 7 clk per 56, cyc_cnt_o=1 after first X3->A1.
REQ-031 SHALL cover: 256 instruction cycles -> cyc_cnt_o wraps 255->0, no error.
REQ-032 SHALL cover: stop_i=1 across X3->A1 -> stopped_o=1, state_o=0, SYNC_o=1, no sub_stb_o for 3 PHI2 edges; stop_i=0 -> state_o=1 two PHI2 edges later.
REQ-033 SHALL cover: PHI2_i held 1 for 20 clk, WDOG_LIMIT=15 -> phase_err_o=1 at 15th clk, stays 1 after clock resumes until rst_i.
REQ-034 SHALL cover: PHI1_i=PHI2_i=0 for 1 clk -> phase_err_o=1 next clk.
REQ-035 SHALL cover: rst_i at state_o=5 with PHI2_i=1 -> all outputs at reset values next clk, first advance only on a genuine low->high PHI2.
